cv32e40p_fpu_req_buffer: RTL and testbench

//   Parametrised request buffer between the CV32E40P FP decoder and the FPnew wrapper. Holds
//   FP requests (operation, modifier, formats, rounding mode, operands, tag) in a DEPTH-entry

---
 rtl/cv32e40p_fpu_req_buffer.sv | 153 +++++++++++++++
 tb/tb_cv32e40p_fpu_req_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_fpu_req_buffer.sv
// FP request FIFO between the CV32E40P FP decoder and the FPnew wrapper.
// Tracks per-group occupancy and drops illegal encodings with a one-cycle flag.
module cv32e40p_fpu_req_buffer #(
   parameter int DEPTH        = 4,
   parameter int FLEN         = 32,
   parameter int NUM_OPERANDS = 3,
   parameter int TAG_WIDTH    = 5,
   parameter bit FALL_THROUGH = 1'b0,
   localparam int CW          = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [3:0]                   in_op_i,
   input  logic                         in_op_mod_i,
   input  logic [2:0]                   in_src_fmt_i,
   input  logic [2:0]                   in_dst_fmt_i,
   input  logic [1:0]                   in_int_fmt_i,
   input  logic [2:0]                   in_rnd_i,
   input  logic [NUM_OPERANDS*FLEN-1:0] in_operands_i,
   input  logic [TAG_WIDTH-1:0]         in_tag_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [3:0]                   out_op_o,
   output logic                         out_op_mod_o,
   output logic [2:0]                   out_src_fmt_o,
   output logic [2:0]                   out_dst_fmt_o,
   output logic [1:0]                   out_int_fmt_o,
   output logic [2:0]                   out_rnd_o,
   output logic [NUM_OPERANDS*FLEN-1:0] out_operands_o,
   output logic [TAG_WIDTH-1:0]         out_tag_o,
   output logic [CW-1:0]                count_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [3:0]                   grp_pending_o,
   output logic                         illegal_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = NUM_OPERANDS * FLEN;
   localparam int EW = 16 + OW + TAG_WIDTH;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   function automatic logic [1:0] grp_of(input logic [3:0] op);
      unique case (1'b1)
         (op <= 4'd3):                 grp_of = 2'd0;
         (op >= 4'd4 && op <= 4'd5):   grp_of = 2'd1;
         (op >= 4'd6 && op <= 4'd9):   grp_of = 2'd2;
         default:                      grp_of = 2'd3;
      endcase
   endfunction

   function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
      ptr_nxt = (p == LAST) ? '0 : p + 1'b1;
   endfunction

   logic [EW-1:0]   mem [DEPTH];
   logic [PW-1:0]   wptr, rptr;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   grp_cnt [4];
   logic            illegal_q;

   logic [EW-1:0]   in_word, head_word, out_word;
   logic            legal, bypass, push, pop, wr, rd;
   logic [1:0]      in_grp, head_grp;

   assign in_word = {in_op_i, in_op_mod_i, in_src_fmt_i, in_dst_fmt_i,
                     in_int_fmt_i, in_rnd_i, in_operands_i, in_tag_i};

   assign legal = (in_op_i != 4'd15) && (in_src_fmt_i <= 3'd4)
               && (in_dst_fmt_i <= 3'd4);

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CW'(DEPTH));
   assign count_o    = count_q;
   assign illegal_o  = illegal_q;
   assign in_ready_o = !full_o && !flush_i;

   assign bypass = FALL_THROUGH && empty_o;
   assign head_word = mem[rptr];
   assign out_word  = bypass ? in_word : head_word;

   assign {out_op_o, out_op_mod_o, out_src_fmt_o, out_dst_fmt_o,
           out_int_fmt_o, out_rnd_o, out_operands_o, out_tag_o} = out_word;

   assign out_valid_o = bypass ? (in_valid_i && legal && !flush_i) : !empty_o;

   assign push = in_valid_i && in_ready_o && legal;
   assign pop  = out_valid_o && out_ready_i && !flush_i;

   // A bypassed request consumed in the same cycle never touches storage
   assign wr = push && !(bypass && pop);
   assign rd = pop && !bypass;

   assign in_grp   = grp_of(in_op_i);
   assign head_grp = grp_of(head_word[EW-1 -: 4]);

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= in_word;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wptr      <= '0;
         rptr      <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
         for (int g = 0; g < 4; g++) grp_cnt[g] <= '0;
      end else begin
         illegal_q <= in_valid_i && in_ready_o && !legal;
         if (wr) wptr <= ptr_nxt(wptr);
         if (rd) rptr <= ptr_nxt(rptr);
         unique case ({wr, rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         for (int g = 0; g < 4; g++) begin
            if (wr && in_grp == 2'(g) && !(rd && head_grp == 2'(g)))
               grp_cnt[g] <= grp_cnt[g] + 1'b1;
            else if (rd && head_grp == 2'(g) && !(wr && in_grp == 2'(g)))
               grp_cnt[g] <= grp_cnt[g] - 1'b1;
         end
      end
   end

   always_comb begin
      grp_pending_o = '0;
      for (int g = 0; g < 4; g++) grp_pending_o[g] = (grp_cnt[g] != '0);
   end

   logic [CW+1:0] grp_sum;

   always_comb begin
      grp_sum = '0;
      for (int g = 0; g < 4; g++) grp_sum = grp_sum + (CW+2)'(grp_cnt[g]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count_q <= CW'(DEPTH));
         assert (grp_sum == (CW+2)'(count_q));
      end
   end

   if (!FALL_THROUGH) begin : g_stable
      assert property (@(posedge clk) disable iff (rst)
         (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_word));
   end

endmodule

// File: tb/tb_cv32e40p_fpu_req_buffer.sv
// Directed bench for cv32e40p_fpu_req_buffer: vector table plus
// hand sequences for wrap-around ordering and fall-through.
module tb_cv32e40p_fpu_req_buffer;

   localparam int OW = 96;

   logic          clk = 1'b0;
   logic          rst, flush, iv, mod, ordy;
   logic [3:0]    op;
   logic [2:0]    sf, df, rnd;
   logic [1:0]    ifmt;
   logic [OW-1:0] opnd;
   logic [4:0]    tag;

   logic          a_ir, a_ov, a_full, a_empty, a_ill, a_mod;
   logic [3:0]    a_op, a_grp;
   logic [2:0]    a_sf, a_df, a_rnd, a_cnt;
   logic [1:0]    a_ifmt;
   logic [OW-1:0] a_opnd;
   logic [4:0]    a_tag;

   logic          b_ir, b_ov, b_full, b_empty, b_ill, b_mod;
   logic [3:0]    b_op, b_grp;
   logic [2:0]    b_sf, b_df, b_rnd, b_cnt;
   logic [1:0]    b_ifmt;
   logic [OW-1:0] b_opnd;
   logic [4:0]    b_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cv32e40p_fpu_req_buffer #(.FALL_THROUGH(1'b0)) dut_a (
      .clk(clk), .rst(rst), .flush_i(flush),
      .in_valid_i(iv), .in_ready_o(a_ir),
      .in_op_i(op), .in_op_mod_i(mod), .in_src_fmt_i(sf),
      .in_dst_fmt_i(df), .in_int_fmt_i(ifmt), .in_rnd_i(rnd),
      .in_operands_i(opnd), .in_tag_i(tag),
      .out_valid_o(a_ov), .out_ready_i(ordy),
      .out_op_o(a_op), .out_op_mod_o(a_mod), .out_src_fmt_o(a_sf),
      .out_dst_fmt_o(a_df), .out_int_fmt_o(a_ifmt), .out_rnd_o(a_rnd),
      .out_operands_o(a_opnd), .out_tag_o(a_tag),
      .count_o(a_cnt), .full_o(a_full), .empty_o(a_empty),
      .grp_pending_o(a_grp), .illegal_o(a_ill)
   );

   cv32e40p_fpu_req_buffer #(.FALL_THROUGH(1'b1)) dut_b (
      .clk(clk), .rst(rst), .flush_i(flush),
      .in_valid_i(iv), .in_ready_o(b_ir),
      .in_op_i(op), .in_op_mod_i(mod), .in_src_fmt_i(sf),
      .in_dst_fmt_i(df), .in_int_fmt_i(ifmt), .in_rnd_i(rnd),
      .in_operands_i(opnd), .in_tag_i(tag),
      .out_valid_o(b_ov), .out_ready_i(ordy),
      .out_op_o(b_op), .out_op_mod_o(b_mod), .out_src_fmt_o(b_sf),
      .out_dst_fmt_o(b_df), .out_int_fmt_o(b_ifmt), .out_rnd_o(b_rnd),
      .out_operands_o(b_opnd), .out_tag_o(b_tag),
      .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty),
      .grp_pending_o(b_grp), .illegal_o(b_ill)
   );

   typedef struct {
      logic       r, f, v;
      logic [3:0] op;
      logic [2:0] sf, df;
      logic [4:0] tag;
      logic       ordy;
      logic       e_ir, e_ov;
      logic [2:0] e_cnt;
      logic [3:0] e_grp;
      logic       e_ill;
      logic [4:0] e_tag;
   } vec_t;

   vec_t tv[22];

   function automatic vec_t mk(
      input logic r, f, v, input logic [3:0] o, input logic [2:0] s, d,
      input logic [4:0] t, input logic rd, input logic eir, eov,
      input logic [2:0] ecnt, input logic [3:0] egrp, input logic eill,
      input logic [4:0] etag);
      vec_t x;
      x.r = r; x.f = f; x.v = v; x.op = o; x.sf = s; x.df = d;
      x.tag = t; x.ordy = rd; x.e_ir = eir; x.e_ov = eov;
      x.e_cnt = ecnt; x.e_grp = egrp; x.e_ill = eill; x.e_tag = etag;
      return x;
   endfunction

   function automatic logic [OW-1:0] pat(input int k);
      return {32'hA500_0000 + k, 32'h5A00_0000 + 3 * k, 32'hC300_0000 ^ k};
   endfunction

   task automatic chk(input string nm, input logic [OW-1:0] act,
                      input logic [OW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0;
      op = '0; mod = 1'b0; sf = '0; df = '0; ifmt = 2'd1; rnd = 3'd2;
      opnd = pat(99); tag = '0;

      //          r f v op sf df tag rd  ir ov cnt grp     ill tag
      tv[0]  = mk(0,0,1, 2, 0, 0, 1, 0,  1, 0, 0, 4'b0000, 0, 0);
      tv[1]  = mk(0,0,1, 4, 0, 0, 2, 0,  1, 1, 1, 4'b0001, 0, 1);
      tv[2]  = mk(0,0,1, 6, 0, 0, 3, 0,  1, 1, 2, 4'b0011, 0, 1);
      tv[3]  = mk(0,0,1,11, 0, 0, 4, 0,  1, 1, 3, 4'b0111, 0, 1);
      tv[4]  = mk(0,0,1, 2, 0, 0, 5, 0,  0, 1, 4, 4'b1111, 0, 1);
      tv[5]  = mk(0,0,1, 2, 0, 0, 5, 1,  0, 1, 4, 4'b1111, 0, 1);
      tv[6]  = mk(0,0,0, 0, 0, 0, 0, 0,  1, 1, 3, 4'b1110, 0, 2);
      tv[7]  = mk(0,0,1,15, 0, 0, 6, 0,  1, 1, 3, 4'b1110, 0, 2);
      tv[8]  = mk(0,0,1, 2, 5, 0, 7, 0,  1, 1, 3, 4'b1110, 1, 2);
      tv[9]  = mk(0,0,0, 0, 0, 0, 0, 0,  1, 1, 3, 4'b1110, 1, 2);
      tv[10] = mk(0,0,0, 0, 0, 0, 0, 0,  1, 1, 3, 4'b1110, 0, 2);
      tv[11] = mk(0,1,1, 2, 0, 0, 9, 1,  0, 1, 3, 4'b1110, 0, 2);
      tv[12] = mk(0,0,0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 0, 0);
      tv[13] = mk(0,0,1, 3, 0, 0,10, 0,  1, 0, 0, 4'b0000, 0, 0);
      tv[14] = mk(0,0,1, 4, 0, 0,11, 1,  1, 1, 1, 4'b0001, 0,10);
      tv[15] = mk(0,0,1, 6, 0, 0,12, 0,  1, 1, 1, 4'b0010, 0,11);
      tv[16] = mk(1,0,0, 0, 0, 0, 0, 0,  1, 1, 2, 4'b0110, 0,11);
      tv[17] = mk(0,0,0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 0, 0);
      tv[18] = mk(0,1,1,15, 0, 0,13, 0,  0, 0, 0, 4'b0000, 0, 0);
      tv[19] = mk(0,0,1, 2, 0, 5,14, 0,  1, 0, 0, 4'b0000, 0, 0);
      tv[20] = mk(0,0,0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 1, 0);
      tv[21] = mk(0,0,0, 0, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 0, 0);

      do_reset();
      @(negedge clk);
      chk("rst count", OW'(a_cnt), 0);
      chk("rst empty", OW'(a_empty), 1);
      chk("rst full", OW'(a_full), 0);
      chk("rst out_valid", OW'(a_ov), 0);
      chk("rst illegal", OW'(a_ill), 0);
      chk("rst grp", OW'(a_grp), 0);
      chk("rst in_ready", OW'(a_ir), 1);

      for (int i = 0; i < 22; i++) begin
         @(posedge clk); #1;
         rst = tv[i].r; flush = tv[i].f; iv = tv[i].v; op = tv[i].op;
         sf = tv[i].sf; df = tv[i].df; tag = tv[i].tag; ordy = tv[i].ordy;
         opnd = pat(i);
         @(negedge clk);
         chk($sformatf("v%0d in_ready", i), OW'(a_ir), OW'(tv[i].e_ir));
         chk($sformatf("v%0d out_valid", i), OW'(a_ov), OW'(tv[i].e_ov));
         chk($sformatf("v%0d count", i), OW'(a_cnt), OW'(tv[i].e_cnt));
         chk($sformatf("v%0d grp", i), OW'(a_grp), OW'(tv[i].e_grp));
         chk($sformatf("v%0d illegal", i), OW'(a_ill), OW'(tv[i].e_ill));
         chk($sformatf("v%0d full", i), OW'(a_full), OW'(tv[i].e_cnt == 3'd4));
         chk($sformatf("v%0d empty", i), OW'(a_empty), OW'(tv[i].e_cnt == 3'd0));
         if (tv[i].e_ov)
            chk($sformatf("v%0d out_tag", i), OW'(a_tag), OW'(tv[i].e_tag));
      end

      // ordering across pointer wrap with random back-pressure
      do_reset();
      begin
         int sent = 0, got = 0, cyc = 0;
         while (got < 10 && cyc < 400) begin
            @(posedge clk); #1;
            iv = (sent < 10); op = 4'(sent % 15); sf = 3'(sent % 5);
            df = 3'((sent + 2) % 5); tag = 5'(sent); opnd = pat(sent);
            ordy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (a_ov && ordy) begin
               chk($sformatf("wrap tag%0d", got), OW'(a_tag), OW'(got));
               chk($sformatf("wrap opnd%0d", got), a_opnd, pat(got));
               chk($sformatf("wrap op%0d", got), OW'(a_op), OW'(got % 15));
               got++;
            end
            if (iv && a_ir) sent++;
            chk("wrap count<=4", OW'(a_cnt <= 3'd4), 1);
            cyc++;
         end
         chk("wrap drained", OW'(got), 10);
      end

      // fall-through: same-cycle pass when empty and consumed
      do_reset();
      @(posedge clk); #1;
      iv = 1'b1; op = 4'd3; sf = '0; df = '0; tag = 5'd7;
      opnd = pat(7); ordy = 1'b1;
      @(negedge clk);
      chk("ft out_valid", OW'(b_ov), 1);
      chk("ft out_tag", OW'(b_tag), 7);
      chk("ft operands", b_opnd, pat(7));
      chk("ft count", OW'(b_cnt), 0);
      @(posedge clk); #1;
      iv = 1'b0; ordy = 1'b0;
      @(negedge clk);
      chk("ft after count", OW'(b_cnt), 0);
      chk("ft after empty", OW'(b_empty), 1);
      chk("ft after out_valid", OW'(b_ov), 0);
      chk("ft after grp", OW'(b_grp), 0);

      // fall-through not consumed: entry lands in storage
      @(posedge clk); #1;
      iv = 1'b1; op = 4'd4; tag = 5'd9; opnd = pat(9); ordy = 1'b0;
      @(negedge clk);
      chk("ft stall out_valid", OW'(b_ov), 1);
      chk("ft stall out_tag", OW'(b_tag), 9);
      @(posedge clk); #1;
      iv = 1'b0;
      @(negedge clk);
      chk("ft held count", OW'(b_cnt), 1);
      chk("ft held tag", OW'(b_tag), 9);
      chk("ft held grp", OW'(b_grp), 4'b0010);
      chk("ft held opnd", b_opnd, pat(9));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
